bit_reversal_restore: RTL
=========================

# bit_reversal_restore

Inverse of `bit_reversal_count`: accepts a 1024-sample group delivered in bit-reversed order and emits it in natural index order. Sits at the FFT output, ahead of the power/mel stage. Uses a ping-pong pair of N-entry sample banks: one group is written while the previous group is read out. The output keeps the same group-tagged streaming convention as the input (`do_en`, `out_group_num`, `out_group_idx`).

## Interface
- `I_BW`, 14: input sample width (signed).
- `O_BW`, 14: output sample width (signed), `O_BW >= I_BW`, sign-extended.
- `N`, 1024: group length, power of two; `LOG2N = $clog2(N)` = 10.
- `G_BW`, 7: group-number width.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Synchronous, active-low reset.
- `di_en`: input, 1 bit. Input sample valid, one sample per cycle maximum.
- `data_i`: input, I_BW bits, signed. Input sample.
- `in_group_num`: input, G_BW bits. Group number of the input sample.
- `in_group_idx`: input, LOG2N bits. Arrival position k of the sample within its group (0..N-1).
- `do_en`: output, 1 bit. Output sample valid.
- `data_o`: output, O_BW bits, signed. Output sample in natural order.
- `out_group_num`: output, G_BW bits. Group number of the group being emitted.
- `out_group_idx`: output, LOG2N bits. Natural index 0..N-1 of `data_o`.
- `seq_err`: output, 1 bit. One-cycle pulse when `in_group_idx` differs from the expected position.
- `ovf_err`: output, 1 bit. One-cycle pulse when a bank swap occurs while readout is still active.

## Operation
- Write side:
  - On `di_en`=1, write `data_i` to the write bank at address bitrev(`in_group_idx`). The address is the `in_group_idx` bits reversed.
  - `in_group_idx` is authoritative for the write address.
  - Internal counter `wr_exp` tracks the expected index:
    - If `in_group_idx != wr_exp`, pulse `seq_err`.
    - In all cases `wr_exp <= in_group_idx + 1`, wrapping N-1 to 0.
  - `di_en`=0 holds all write state. Gaps of any length are legal.
- Swap: an accepted sample with `in_group_idx == N-1` is the last write of the group. On that edge:
  - Toggle the bank select.
  - Latch `in_group_num` into the read-group register.
  - Start readout of the just-filled bank.
- Read-side FSM states:
  - IDLE: no readout in progress. Goes to READ on swap.
  - READ: `rd_addr` runs 0..N-1, one per cycle, no stalls.
    - At `rd_addr == N-1`, return to IDLE, unless a swap occurs on the same edge, in which case stay in READ with `rd_addr <= 0`.
- Overflow: if a swap occurs while in READ with `rd_addr != N-1`:
  - Pulse `ovf_err`.
  - Truncate the current readout.
  - Restart `rd_addr` at 0 on the new bank with the new group number.
  - With one sample per cycle and the first index at 0, this cannot happen. It only occurs after index skips.
- Output:
  - `data_o` is the bank word sign-extended to O_BW.
  - `out_group_idx` equals the read address of that word.
  - `out_group_num` is the latched group number.
- Reset (`rst`=0 at an edge):
  - Outputs go to 0: `do_en`, `data_o`, `out_group_num`, `out_group_idx`, `seq_err`, `ovf_err`.
  - Bank select goes to 0, `wr_exp` to 0, FSM to IDLE.
  - A partial group or readout in progress is discarded.
  - Bank contents are not cleared. They are never read before being rewritten after a swap.

## Timing
- Banks are synchronous-read memories with one cycle of read latency. `data_o` and its tags are registered, giving a 2-stage read pipeline.
- Last write (idx N-1) accepted at edge E:
  - First `do_en`=1 with `out_group_idx`=0 appears after edge E+2.
  - Natural index j appears after edge E+2+j.
  - `do_en` drops after edge E+N+2 unless the next readout follows back to back.
- Back-to-back groups at 1 sample per cycle give a continuous `do_en`. `out_group_idx` wraps 1023 to 0 with no bubble.
- `seq_err` and `ovf_err` are registered and asserted for exactly the cycle after the offending edge.
- A write and a read of the same bank never occur in the same cycle.
- Read-to-write conflict inside a bank is impossible by construction, since the swap selects the opposite bank.

## Test plan
- Single group, bit-reversed ramp:
  - Stimulus: group 3, k=0..1023 with `data_i`=bitrev(k), continuous.
  - Required: `do_en` for 1024 cycles starting at E+2, `data_o`=`out_group_idx`=0..1023, `out_group_num`=3, no error pulses.
  - Spot checks: k=1 writes address 512, k=2 writes 256, k=3 writes 768.
- Continuous streaming:
  - Stimulus: groups 0..3 back to back with `data_i`=group·1024+bitrev(k), truncated to 14 bits signed.
  - Required: gapless `do_en` over 4096 cycles, correct natural order, group numbers 0..3 in sequence.
- Sparse input:
  - Stimulus: `di_en` toggles 1/0 every cycle for one group.
  - Required: identical output to the continuous case, starting 2 cycles after the final write.
- Sign extension:
  - Stimulus: `O_BW`=16, `data_i`=-8192 at k=0.
  - Required: `data_o`=-8192 (16'hE000) at `out_group_idx`=0.
- Index skip and overflow:
  - Stimulus: after k=0..9, jump to k=1023 while the previous readout is at `rd_addr` 100.
  - Required: `seq_err` pulses at the jump, `ovf_err` pulses at the swap, readout restarts at `out_group_idx`=0 with the new group number.
- Reset mid-readout:
  - Stimulus: `rst`=0 for one cycle at `out_group_idx`=500.
  - Required: next cycle all outputs are 0 and `do_en`=0. A fresh group then behaves as in the first scenario.

Source files
------------

// File: rtl/bit_reversal_restore.sv
// Bit-reversed to natural-order reorder buffer for one FFT output stream.
// Ping-pong sample banks: one group is written while the previous one is read out.

module bit_reversal_restore_bank #(
    parameter int W     = 14,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // Plain simple-dual-port RAM with registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module bit_reversal_restore #(
    parameter int I_BW  = 14,
    parameter int O_BW  = 14,
    parameter int N     = 1024,
    parameter int G_BW  = 7,
    parameter int LOG2N = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    di_en,
    input  logic signed [I_BW-1:0]  data_i,
    input  logic [G_BW-1:0]         in_group_num,
    input  logic [LOG2N-1:0]        in_group_idx,
    output logic                    do_en,
    output logic signed [O_BW-1:0]  data_o,
    output logic [G_BW-1:0]         out_group_num,
    output logic [LOG2N-1:0]        out_group_idx,
    output logic                    seq_err,
    output logic                    ovf_err
);
    localparam int STAGES = 1;

    typedef enum logic {IDLE, READ} state_t;

    state_t                  state;
    logic                    wr_sel, rd_bank, rd_bank_p;
    logic [LOG2N-1:0]        wr_exp, rd_addr, idx_p, wr_addr;
    logic [G_BW-1:0]         rd_grp, grp_p;
    logic [STAGES:0]         vld_pipe;
    logic [1:0][I_BW-1:0]    bank_q;
    logic signed [I_BW-1:0]  rd_word;
    logic                    wr_go, swap, rd_go, last_rd;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    assign wr_go   = rst && di_en;
    assign swap    = wr_go && (in_group_idx == LOG2N'(N-1));
    assign rd_go   = (state == READ);
    assign last_rd = (rd_addr == LOG2N'(N-1));
    assign wr_addr = bitrev(in_group_idx);
    assign rd_word = bank_q[rd_bank_p];
    assign do_en   = vld_pipe[STAGES];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bit_reversal_restore_bank #(.W(I_BW), .DEPTH(N)) u_bank (
            .clk   (clk),
            .we    (wr_go && (wr_sel == 1'(b))),
            .waddr (wr_addr),
            .wdata (data_i),
            .re    (rd_go && (rd_bank == 1'(b))),
            .raddr (rd_addr),
            .rdata (bank_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            wr_sel        <= 1'b0;
            rd_bank       <= 1'b0;
            rd_bank_p     <= 1'b0;
            wr_exp        <= '0;
            rd_addr       <= '0;
            rd_grp        <= '0;
            idx_p         <= '0;
            grp_p         <= '0;
            vld_pipe      <= '0;
            data_o        <= '0;
            out_group_num <= '0;
            out_group_idx <= '0;
            seq_err       <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            seq_err <= di_en && (in_group_idx != wr_exp);
            ovf_err <= swap && rd_go && !last_rd;
            if (di_en) wr_exp <= in_group_idx + 1'b1;

            // Tags ride alongside the RAM read so they line up with its data.
            vld_pipe  <= {vld_pipe[STAGES-1:0], rd_go};
            idx_p     <= rd_addr;
            grp_p     <= rd_grp;
            rd_bank_p <= rd_bank;
            if (vld_pipe[0]) begin
                data_o        <= O_BW'(rd_word);
                out_group_idx <= idx_p;
                out_group_num <= grp_p;
            end

            // A swap always wins: it (re)starts readout of the bank just filled.
            if (swap) begin
                wr_sel  <= ~wr_sel;
                rd_bank <= wr_sel;
                rd_grp  <= in_group_num;
                rd_addr <= '0;
                state   <= READ;
            end else if (rd_go) begin
                if (last_rd) state <= IDLE;
                else         rd_addr <= rd_addr + 1'b1;
            end
        end
    end
endmodule
